gnn_engine_param: RTL
=====================

Name: gnn_engine_param

Overview:
- Parametrised, time-multiplexed successor of the fixed 4-node, 2-layer graph DNN top.
- Holds N graph nodes with F input features, H hidden neurons and O outputs per node.
- Adjacency is a runtime input (N×N bit mask), not fixed wiring. Pipeline per transaction: neighbour aggregation -> layer-1 MAC + ReLU -> hidden aggregation -> layer-2 MAC.
- One hidden/output neuron is computed per cycle, for all nodes in parallel. Uses valid/ready handshakes on input and output.

Parameters:
- N, 4, node count (≥2)
- F, 4, input features per node
- H, 4, hidden neurons (layer 1)
- O, 2, outputs per node (layer 2)
- XW, 5, signed feature width
- WW, 5, signed weight width
- SELF_LOOP, 1, 1 forces adj diagonal to 1 regardless of the adj input
- localparam AW = XW+$clog2(N), aggregated feature width
- localparam HW = AW+WW+$clog2(F), hidden width
- localparam GW = HW+$clog2(N), aggregated hidden width
- localparam OW = GW+WW+$clog2(H), output width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction offered
- in_ready  out  1  engine can accept
- x  in  N*F*XW  signed features; node n, feature f at index (n*F+f)*XW
- adj  in  N*N  bit n*N+m =1: node m contributes to node n's aggregate
- w1  in  F*H*WW  signed; weight f->h at index (f*H+h)*WW
- w2  in  H*O*WW  signed; weight h->o at index (h*O+o)*WW
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- out  out  N*O*OW  signed; node n, output o at index (n*O+o)*OW
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, out=0. All counters and internal registers clear to 0.
- States: IDLE, XAGG, L1, HAGG, L2, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: capture x, adj (SELF_LOOP applied), w1, w2 into registers; go to XAGG. Inputs are don't-care after the accept edge.
- XAGG (1 cycle): xa[n][f] = sign-extended sum over m with adj[n][m]=1 of x[m][f], stored at AW bits. Rows with no set bit give 0. Go to L1, h_cnt=0.
- L1 (H cycles): for all n, hid[n][h_cnt] = ReLU(sum_f xa[n][f]*w1[f][h_cnt]), HW bits. After h_cnt=H-1, go to HAGG.
- HAGG (1 cycle): ha[n][h] = sum over m with adj[n][m]=1 of hid[m][h], GW bits, using the same adjacency. Go to L2, o_cnt=0.
- L2 (O cycles): out[n][o_cnt] = sum_h ha[n][h]*w2[h][o_cnt], OW bits, no activation. After o_cnt=O-1, go to DONE.
- DONE: out_valid=1, out stable. On out_ready go to IDLE, clear out_valid. in_ready=0 in every non-IDLE state.
- Latency: the accept edge is cycle 0; out_valid rises at the end of cycle H+O+2 (8 at defaults). Throughput is one transaction per H+O+4 cycles if out_ready is held high.
- Arithmetic: all signed, full-width sign extension, no saturation. Widths are sized so no overflow occurs for any operand values.
- in_valid during a non-IDLE state is ignored; the transaction is not queued.
- out_ready outside DONE has no effect.
- Reset mid-operation: immediate return to IDLE with reset values; partial results are discarded.
- out holds its last value after DONE->IDLE until overwritten during the next L2.

Test Plan:
- Reset -> in_ready=1, out_valid=0, busy=0, out=0. Release, then idle 10 cycles -> no change.
- Defaults, 4-node diamond adj (rows: 0:{0,1,2}, 1:{0,1,3}, 2:{0,2,3}, 3:{1,2,3}), all x=1, w1=w2=1 -> every out = 4*(3*12)=144. out_valid rises 8 cycles after accept.
- Same as previous with w1 all -1 -> hidden ReLU'd to 0 -> all out=0.
- Full adj, x=-16, w1=w2=-16 -> xa=-64, hid=4096, ha=16384, out=-1048576 (fits OW=23).
- out_ready low 5 cycles in DONE -> out_valid held, out stable, in_ready=0. in_valid pulses ignored. Next accept only after DONE->IDLE.
- rst_n low during L1 -> IDLE immediately, out=0. Re-run the second scenario -> 144 everywhere with correct latency.

Source files
------------

// File: rtl/gnn_engine_param.sv
`default_nettype none
// ============================================================================
// Module   : gnn_engine_param
// Purpose  : Time-multiplexed two-layer graph neural network engine.
//            A transaction passes through four steps:
//              1. neighbour aggregation of the input features
//              2. layer-1 MAC with ReLU
//              3. neighbour aggregation of the hidden activations
//              4. layer-2 MAC
//            Each cycle of the MAC phases computes one neuron for all N
//            nodes in parallel. Adjacency is supplied at run time.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            in_valid/in_ready   input handshake (accepted only in IDLE)
//            x, adj, w1, w2      features, adjacency mask, layer weights
//            out_valid/out_ready output handshake (held in DONE)
//            out                 N*O signed results, OW bits each
//            busy                engine is not idle
// Revision : 1.0 - initial release
// ============================================================================
module gnn_engine_param #(
  parameter  int N         = 4,
  parameter  int F         = 4,
  parameter  int H         = 4,
  parameter  int O         = 2,
  parameter  int XW        = 5,
  parameter  int WW        = 5,
  parameter  int SELF_LOOP = 1,
  localparam int AW        = XW + $clog2(N),
  localparam int HW        = AW + WW + $clog2(F),
  localparam int GW        = HW + $clog2(N),
  localparam int OW        = GW + WW + $clog2(H)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*F*XW-1:0]   x,
  input  logic [N*N-1:0]      adj,
  input  logic [F*H*WW-1:0]   w1,
  input  logic [H*O*WW-1:0]   w2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*O*OW-1:0]   out,
  output logic                busy
);

  localparam int HCW = (H > 1) ? $clog2(H) : 1;
  localparam int OCW = (O > 1) ? $clog2(O) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XAGG = 3'd1,
    S_L1   = 3'd2,
    S_HAGG = 3'd3,
    S_L2   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [HCW-1:0]         h_cnt_q, h_cnt_d;
  logic [OCW-1:0]         o_cnt_q, o_cnt_d;

  logic [N*F*XW-1:0]      x_q, x_d;
  logic [N*N-1:0]         adj_q, adj_d;
  logic [F*H*WW-1:0]      w1_q, w1_d;
  logic [H*O*WW-1:0]      w2_q, w2_d;

  logic signed [AW-1:0]   xa_q  [N][F];
  logic signed [AW-1:0]   xa_d  [N][F];
  logic signed [HW-1:0]   hid_q [N][H];
  logic signed [HW-1:0]   hid_d [N][H];
  logic signed [GW-1:0]   ha_q  [N][H];
  logic signed [GW-1:0]   ha_d  [N][H];
  logic [N*O*OW-1:0]      out_q, out_d;

  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  // Scratch accumulators; each is cleared before every sum it builds.
  logic signed [AW-1:0]   acc_x;
  logic signed [HW-1:0]   acc_h;
  logic signed [GW-1:0]   acc_g;
  logic signed [OW-1:0]   acc_o;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    o_cnt_d = o_cnt_q;
    x_d     = x_q;
    adj_d   = adj_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    xa_d    = xa_q;
    hid_d   = hid_q;
    ha_d    = ha_q;
    out_d   = out_q;
    acc_x   = '0;
    acc_h   = '0;
    acc_g   = '0;
    acc_o   = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d   = x;
          adj_d = adj;
          if (SELF_LOOP != 0) begin
            for (int n = 0; n < N; n++) adj_d[n*N+n] = 1'b1;
          end
          w1_d    = w1;
          w2_d    = w2;
          state_d = S_XAGG;
        end
      end

      S_XAGG: begin
        for (int n = 0; n < N; n++) begin
          for (int f = 0; f < F; f++) begin
            acc_x = '0;
            for (int m = 0; m < N; m++) begin
              if (adj_q[n*N+m]) acc_x = acc_x + AW'($signed(x_q[(m*F+f)*XW +: XW]));
            end
            xa_d[n][f] = acc_x;
          end
        end
        h_cnt_d = '0;
        state_d = S_L1;
      end

      S_L1: begin
        for (int n = 0; n < N; n++) begin
          acc_h = '0;
          for (int f = 0; f < F; f++) begin
            acc_h = acc_h + HW'(xa_q[n][f]) *
                    HW'($signed(w1_q[(f*H + int'(h_cnt_q))*WW +: WW]));
          end
          hid_d[n][h_cnt_q] = acc_h[HW-1] ? '0 : acc_h;
        end
        if (h_cnt_q == HCW'(H-1)) begin
          state_d = S_HAGG;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end

      S_HAGG: begin
        for (int n = 0; n < N; n++) begin
          for (int h = 0; h < H; h++) begin
            acc_g = '0;
            for (int m = 0; m < N; m++) begin
              if (adj_q[n*N+m]) acc_g = acc_g + GW'(hid_q[m][h]);
            end
            ha_d[n][h] = acc_g;
          end
        end
        o_cnt_d = '0;
        state_d = S_L2;
      end

      S_L2: begin
        for (int n = 0; n < N; n++) begin
          acc_o = '0;
          for (int h = 0; h < H; h++) begin
            acc_o = acc_o + OW'(ha_q[n][h]) *
                    OW'($signed(w2_q[(h*O + int'(o_cnt_q))*WW +: WW]));
          end
          out_d[(n*O + int'(o_cnt_q))*OW +: OW] = acc_o;
        end
        if (o_cnt_q == OCW'(O-1)) begin
          state_d = S_DONE;
        end else begin
          o_cnt_d = o_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode so
    // they change on the same edge as the state itself.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      o_cnt_q     <= '0;
      x_q         <= '0;
      adj_q       <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int n = 0; n < N; n++) begin
        for (int f = 0; f < F; f++) xa_q[n][f] <= '0;
        for (int h = 0; h < H; h++) begin
          hid_q[n][h] <= '0;
          ha_q[n][h]  <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      o_cnt_q     <= o_cnt_d;
      x_q         <= x_d;
      adj_q       <= adj_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      xa_q        <= xa_d;
      hid_q       <= hid_d;
      ha_q        <= ha_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule
`default_nettype wire
